// File: rtl/rf_op_sequencer_if.sv
// Instruction handshake plus register-file read/write bus between the
// op sequencer (master) and its environment: decoder and register file (slave).
interface rf_op_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8
);
   localparam int AW = $clog2(REG_COUNT);

   logic                  instr_valid;
   logic                  instr_ready;
   logic [2:0]            instr_op;
   logic [AW-1:0]         instr_rd;
   logic [AW-1:0]         instr_rs1;
   logic [AW-1:0]         instr_rs2;
   logic [DATA_WIDTH-1:0] instr_imm;

   logic [AW-1:0]         rf_read_addr1;
   logic [AW-1:0]         rf_read_addr2;
   logic [DATA_WIDTH-1:0] rf_read_data1;
   logic [DATA_WIDTH-1:0] rf_read_data2;
   logic                  rf_write_en;
   logic [AW-1:0]         rf_write_addr;
   logic [DATA_WIDTH-1:0] rf_write_data;

   modport master (
      input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
      input  rf_read_data1, rf_read_data2,
      output instr_ready,
      output rf_read_addr1, rf_read_addr2,
      output rf_write_en, rf_write_addr, rf_write_data
   );

   modport slave (
      output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
      output rf_read_data1, rf_read_data2,
      input  instr_ready,
      input  rf_read_addr1, rf_read_addr2,
      input  rf_write_en, rf_write_addr, rf_write_data
   );
endinterface

// File: rtl/rf_op_sequencer.sv
// Multi-cycle IDLE/FETCH/EXEC/WB sequencer: reads two operands from the
// register file, runs one ALU op and writes the result back.
module rf_op_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rf_op_sequencer_if.master     bus,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero_flag,
   output logic                  carry_flag,
   output logic                  done,
   output logic [CNT_W-1:0]      retired_cnt
);
   localparam int AW = $clog2(REG_COUNT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_ADDI = 3'd5;
   localparam logic [2:0] OP_LI   = 3'd6;
   localparam logic [2:0] OP_NOP  = 3'd7;

   logic [1:0]            state_q,       state_d;
   logic [2:0]            op_q,          op_d;
   logic [AW-1:0]         rd_q,          rd_d;
   logic [DATA_WIDTH-1:0] imm_q,         imm_d;
   logic [AW-1:0]         raddr1_q,      raddr1_d;
   logic [AW-1:0]         raddr2_q,      raddr2_d;
   logic [DATA_WIDTH-1:0] a_q,           a_d;
   logic [DATA_WIDTH-1:0] b_q,           b_d;
   logic [DATA_WIDTH-1:0] result_q,      result_d;
   logic                  zero_q,        zero_d;
   logic                  carry_q,       carry_d;
   logic [CNT_W-1:0]      retired_cnt_q, retired_cnt_d;
   logic                  wen_q,         wen_d;
   logic                  done_q,        done_d;
   logic [AW-1:0]         waddr_q,       waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q,       wdata_d;
   logic                  ready_q,       ready_d;

   logic [DATA_WIDTH:0]   sum_s;
   logic [DATA_WIDTH:0]   diff_s;
   logic [DATA_WIDTH-1:0] addend_s;
   logic [DATA_WIDTH-1:0] alu_res_s;
   logic                  alu_carry_s;

   // ALU on the registered operands; the extra MSB of sum/diff is carry/borrow.
   always_comb begin
      addend_s = (op_q == OP_ADDI) ? imm_q : b_q;
      sum_s    = {1'b0, a_q} + {1'b0, addend_s};
      diff_s   = {1'b0, a_q} - {1'b0, b_q};
      case (op_q)
         OP_ADD, OP_ADDI: begin
            alu_res_s   = sum_s[DATA_WIDTH-1:0];
            alu_carry_s = sum_s[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_res_s   = diff_s[DATA_WIDTH-1:0];
            alu_carry_s = diff_s[DATA_WIDTH];
         end
         OP_AND: begin
            alu_res_s   = a_q & b_q;
            alu_carry_s = 1'b0;
         end
         OP_OR: begin
            alu_res_s   = a_q | b_q;
            alu_carry_s = 1'b0;
         end
         OP_XOR: begin
            alu_res_s   = a_q ^ b_q;
            alu_carry_s = 1'b0;
         end
         OP_LI: begin
            alu_res_s   = imm_q;
            alu_carry_s = 1'b0;
         end
         default: begin
            alu_res_s   = result_q;
            alu_carry_s = carry_q;
         end
      endcase
   end

   // Next-state and datapath capture logic.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      rd_d          = rd_q;
      imm_d         = imm_q;
      raddr1_d      = raddr1_q;
      raddr2_d      = raddr2_q;
      a_d           = a_q;
      b_d           = b_q;
      result_d      = result_q;
      zero_d        = zero_q;
      carry_d       = carry_q;
      retired_cnt_d = retired_cnt_q;
      wen_d         = 1'b0;
      done_d        = 1'b0;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               op_d     = bus.instr_op;
               rd_d     = bus.instr_rd;
               imm_d    = bus.instr_imm;
               raddr1_d = bus.instr_rs1;
               raddr2_d = bus.instr_rs2;
               state_d  = S_FETCH;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_FETCH: begin
            a_d     = bus.rf_read_data1;
            b_d     = bus.rf_read_data2;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (op_q != OP_NOP) begin
               result_d = alu_res_s;
               zero_d   = (alu_res_s == {DATA_WIDTH{1'b0}});
               carry_d  = alu_carry_s;
            end else begin
               result_d = result_q;
               zero_d   = zero_q;
               carry_d  = carry_q;
            end
            // Write strobe is registered here so it rises cleanly on entry to WB.
            wen_d   = (op_q != OP_NOP);
            done_d  = 1'b1;
            waddr_d = rd_q;
            wdata_d = result_d;
            state_d = S_WB;
         end
         S_WB: begin
            retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_q          <= 3'd0;
         rd_q          <= {AW{1'b0}};
         imm_q         <= {DATA_WIDTH{1'b0}};
         raddr1_q      <= {AW{1'b0}};
         raddr2_q      <= {AW{1'b0}};
         a_q           <= {DATA_WIDTH{1'b0}};
         b_q           <= {DATA_WIDTH{1'b0}};
         result_q      <= {DATA_WIDTH{1'b0}};
         zero_q        <= 1'b0;
         carry_q       <= 1'b0;
         retired_cnt_q <= {CNT_W{1'b0}};
         wen_q         <= 1'b0;
         done_q        <= 1'b0;
         waddr_q       <= {AW{1'b0}};
         wdata_q       <= {DATA_WIDTH{1'b0}};
         ready_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         rd_q          <= rd_d;
         imm_q         <= imm_d;
         raddr1_q      <= raddr1_d;
         raddr2_q      <= raddr2_d;
         a_q           <= a_d;
         b_q           <= b_d;
         result_q      <= result_d;
         zero_q        <= zero_d;
         carry_q       <= carry_d;
         retired_cnt_q <= retired_cnt_d;
         wen_q         <= wen_d;
         done_q        <= done_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         ready_q       <= ready_d;
      end
   end

   assign bus.instr_ready   = ready_q;
   assign bus.rf_read_addr1 = raddr1_q;
   assign bus.rf_read_addr2 = raddr2_q;
   assign bus.rf_write_en   = wen_q;
   assign bus.rf_write_addr = waddr_q;
   assign bus.rf_write_data = wdata_q;
   assign result            = result_q;
   assign zero_flag         = zero_q;
   assign carry_flag        = carry_q;
   assign done              = done_q;
   assign retired_cnt       = retired_cnt_q;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 8x8 register file.
module tb_rf_op_sequencer;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_ADDI = 3'd5;
   localparam logic [2:0] OP_LI   = 3'd6;
   localparam logic [2:0] OP_NOP  = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  result;
   logic        zero_flag, carry_flag, done;
   logic [15:0] retired_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int wen_seen = 0, done_seen = 0, acc_seen = 0;
   int cyc = 0, last_acc = 0, prev_acc = 0;
   int w0, d0, a0;
   logic [15:0] exp_cnt;
   logic        rf_init = 1'b1;
   logic [7:0]  rf_mem [8];

   always #5 clk = ~clk;

   rf_op_sequencer_if #(.DATA_WIDTH(8), .REG_COUNT(8)) bus();

   rf_op_sequencer #(.DATA_WIDTH(8), .REG_COUNT(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .result(result),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .done(done),
      .retired_cnt(retired_cnt)
   );

   assign bus.rf_read_data1 = rf_mem[bus.rf_read_addr1];
   assign bus.rf_read_data2 = rf_mem[bus.rf_read_addr2];

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
      end else if (bus.rf_write_en) begin
         rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.rf_write_en) wen_seen <= wen_seen + 1;
      if (done) done_seen <= done_seen + 1;
      if (bus.instr_valid && bus.instr_ready) begin
         acc_seen <= acc_seen + 1;
         last_acc <= cyc;
         prev_acc <= last_acc;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm);
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1;
      bus.instr_rs2 = rs2; bus.instr_imm = imm;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr_op = ~op; bus.instr_rd = ~rd; bus.instr_rs1 = ~rs1;
      bus.instr_rs2 = ~rs2; bus.instr_imm = ~imm;
   endtask

   task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [7:0] imm);
      issue(op, rd, rs1, rs2, imm);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      bus.instr_valid = 1'b0; bus.instr_op = 3'd0; bus.instr_rd = 3'd0;
      bus.instr_rs1 = 3'd0; bus.instr_rs2 = 3'd0; bus.instr_imm = 8'h00;
      rst_n = 1'b0; rf_init = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus.rf_write_en); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", retired_cnt); end
      n_checks++; if ({result, zero_flag, carry_flag} !== 10'h000) begin n_fail++; $display("FAIL reset_result_flags: got %h/%b/%b want 00/0/0", result, zero_flag, carry_flag); end
      n_checks++; if ({bus.rf_read_addr1, bus.rf_read_addr2, bus.rf_write_addr, bus.rf_write_data} !== 17'h00000) begin n_fail++; $display("FAIL reset_bus: got %h %h %h %h want all 0", bus.rf_read_addr1, bus.rf_read_addr2, bus.rf_write_addr, bus.rf_write_data); end
      rf_init = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
      exp_cnt = 16'h0000;
   endtask

   task automatic test_li;
      d0 = done_seen;
      issue(OP_LI, 3'd3, 3'd0, 3'd0, 8'h5A);
      @(negedge clk);
      n_checks++; if (bus.instr_ready !== 1'b0 || bus.rf_write_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL li_fetch: ready/wen/done %b%b%b want 000", bus.instr_ready, bus.rf_write_en, done); end
      @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b0) begin n_fail++; $display("FAIL li_exec_wen: got %b want 0", bus.rf_write_en); end
      @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 3'd3 || bus.rf_write_data !== 8'h5A) begin n_fail++; $display("FAIL li_wb_write: en %b addr %0d data %h want 1 3 5a", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      n_checks++; if (done !== 1'b1 || result !== 8'h5A) begin n_fail++; $display("FAIL li_wb_done: done %b result %h want 1 5a", done, result); end
      @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b0 || done !== 1'b0 || bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL li_after: wen/done/ready %b%b%b want 001", bus.rf_write_en, done, bus.instr_ready); end
      n_checks++; if (rf_mem[3] !== 8'h5A) begin n_fail++; $display("FAIL li_rf: got %h want 5a", rf_mem[3]); end
      n_checks++; if (retired_cnt !== 16'h0001 || done_seen - d0 != 1) begin n_fail++; $display("FAIL li_cnt: cnt %h pulses %0d want 0001 1", retired_cnt, done_seen - d0); end
      exp_cnt = 16'h0001;
   endtask

   task automatic test_arith;
      run(OP_LI, 3'd1, 3'd0, 3'd0, 8'hF0);
      run(OP_LI, 3'd2, 3'd0, 3'd0, 8'h20);
      issue(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 3'd4 || bus.rf_write_data !== 8'h10) begin n_fail++; $display("FAIL add_write: en %b addr %0d data %h want 1 4 10", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      n_checks++; if (carry_flag !== 1'b1 || zero_flag !== 1'b0) begin n_fail++; $display("FAIL add_flags: c %b z %b want 1 0", carry_flag, zero_flag); end
      @(negedge clk);
      n_checks++; if (rf_mem[4] !== 8'h10) begin n_fail++; $display("FAIL add_rf: got %h want 10", rf_mem[4]); end
      issue(OP_SUB, 3'd5, 3'd2, 3'd1, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_addr !== 3'd5 || bus.rf_write_data !== 8'h30 || carry_flag !== 1'b1) begin n_fail++; $display("FAIL sub: addr %0d data %h c %b want 5 30 1", bus.rf_write_addr, bus.rf_write_data, carry_flag); end
      @(negedge clk);
      issue(OP_ADDI, 3'd0, 3'd1, 3'd6, 8'h10);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_data !== 8'h00 || carry_flag !== 1'b1 || zero_flag !== 1'b1) begin n_fail++; $display("FAIL addi_wrap: data %h c %b z %b want 00 1 1", bus.rf_write_data, carry_flag, zero_flag); end
      @(negedge clk);
      issue(OP_AND, 3'd6, 3'd1, 3'd2, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_data !== 8'h20 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin n_fail++; $display("FAIL and: data %h c %b z %b want 20 0 0", bus.rf_write_data, carry_flag, zero_flag); end
      @(negedge clk);
      issue(OP_OR, 3'd7, 3'd1, 3'd2, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_data !== 8'hF0 || carry_flag !== 1'b0) begin n_fail++; $display("FAIL or: data %h c %b want f0 0", bus.rf_write_data, carry_flag); end
      @(negedge clk);
      exp_cnt = exp_cnt + 16'd7;
      n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL arith_cnt: got %h want %h", retired_cnt, exp_cnt); end
      n_checks++; if (rf_mem[0] !== 8'h00 || rf_mem[5] !== 8'h30) begin n_fail++; $display("FAIL arith_rf: r0 %h r5 %h want 00 30", rf_mem[0], rf_mem[5]); end
   endtask

   task automatic test_back_to_back;
      a0 = acc_seen;
      @(negedge clk);
      bus.instr_valid = 1'b1; bus.instr_op = OP_LI; bus.instr_rd = 3'd1;
      bus.instr_rs1 = 3'd0; bus.instr_rs2 = 3'd0; bus.instr_imm = 8'h07;
      @(posedge clk);
      #1;
      bus.instr_op = OP_ADD; bus.instr_rd = 3'd2; bus.instr_rs1 = 3'd1;
      bus.instr_rs2 = 3'd1; bus.instr_imm = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready[%0d]: got %b want 0", i, bus.instr_ready); end
      end
      n_checks++; if (bus.rf_write_addr !== 3'd1 || bus.rf_write_data !== 8'h07) begin n_fail++; $display("FAIL b2b_first_write: addr %0d data %h want 1 07", bus.rf_write_addr, bus.rf_write_data); end
      @(negedge clk);
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready: got %b want 1", bus.instr_ready); end
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0; bus.instr_rs1 = 3'd5; bus.instr_rs2 = 3'd6;
      @(negedge clk);
      n_checks++; if (bus.rf_read_addr1 !== 3'd1 || bus.rf_read_addr2 !== 3'd1) begin n_fail++; $display("FAIL b2b_raddr: %0d %0d want 1 1", bus.rf_read_addr1, bus.rf_read_addr2); end
      repeat (2) @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 3'd2 || bus.rf_write_data !== 8'h0E) begin n_fail++; $display("FAIL b2b_second_write: en %b addr %0d data %h want 1 2 0e", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      @(negedge clk);
      n_checks++; if (rf_mem[2] !== 8'h0E) begin n_fail++; $display("FAIL b2b_rf: got %h want 0e", rf_mem[2]); end
      n_checks++; if (acc_seen - a0 != 2 || last_acc - prev_acc != 4) begin n_fail++; $display("FAIL b2b_spacing: accepts %0d gap %0d want 2 4", acc_seen - a0, last_acc - prev_acc); end
      exp_cnt = exp_cnt + 16'd2;
   endtask

   task automatic test_xor_zero;
      run(OP_LI, 3'd1, 3'd0, 3'd0, 8'h33);
      issue(OP_XOR, 3'd6, 3'd1, 3'd1, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_data !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin n_fail++; $display("FAIL xor: en %b data %h z %b c %b want 1 00 1 0", bus.rf_write_en, bus.rf_write_data, zero_flag, carry_flag); end
      @(negedge clk);
      n_checks++; if (rf_mem[6] !== 8'h00) begin n_fail++; $display("FAIL xor_rf: got %h want 00", rf_mem[6]); end
      exp_cnt = exp_cnt + 16'd2;
   endtask

   task automatic test_nop;
      run(OP_LI, 3'd1, 3'd0, 3'd0, 8'h90);
      issue(OP_ADD, 3'd5, 3'd1, 3'd1, 8'h00);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_data !== 8'h20 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin n_fail++; $display("FAIL nop_setup: data %h c %b z %b want 20 1 0", bus.rf_write_data, carry_flag, zero_flag); end
      @(negedge clk);
      w0 = wen_seen; d0 = done_seen;
      issue(OP_NOP, 3'd3, 3'd1, 3'd1, 8'hFF);
      repeat (3) @(negedge clk);
      n_checks++; if (bus.rf_write_en !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL nop_wb: wen %b done %b want 0 1", bus.rf_write_en, done); end
      n_checks++; if (result !== 8'h20 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin n_fail++; $display("FAIL nop_hold: result %h c %b z %b want 20 1 0", result, carry_flag, zero_flag); end
      @(negedge clk);
      n_checks++; if (wen_seen - w0 != 0 || done_seen - d0 != 1) begin n_fail++; $display("FAIL nop_pulses: wen %0d done %0d want 0 1", wen_seen - w0, done_seen - d0); end
      exp_cnt = exp_cnt + 16'd3;
      n_checks++; if (retired_cnt !== exp_cnt || rf_mem[3] !== 8'h5A) begin n_fail++; $display("FAIL nop_cnt_rf: cnt %h r3 %h want %h 5a", retired_cnt, rf_mem[3], exp_cnt); end
   endtask

   task automatic test_reset_mid;
      run(OP_LI, 3'd7, 3'd0, 3'd0, 8'hAA);
      w0 = wen_seen;
      issue(OP_ADDI, 3'd7, 3'd0, 3'd0, 8'h01);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.rf_write_en !== 1'b0 || done !== 1'b0 || retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL rstmid_async: wen %b done %b cnt %h want 0 0 0000", bus.rf_write_en, done, retired_cnt); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.instr_ready !== 1'b1 || retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL rstmid_idle: ready %b cnt %h want 1 0000", bus.instr_ready, retired_cnt); end
      n_checks++; if (wen_seen - w0 != 0 || rf_mem[7] !== 8'hAA) begin n_fail++; $display("FAIL rstmid_nowrite: writes %0d r7 %h want 0 aa", wen_seen - w0, rf_mem[7]); end
      exp_cnt = 16'h0000;
   endtask

   task automatic test_cnt_wrap;
      @(negedge clk);
      force dut.retired_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.retired_cnt_q;
      @(negedge clk);
      n_checks++; if (retired_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", retired_cnt); end
      run(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00);
      n_checks++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %h want 0000", retired_cnt); end
   endtask

   initial begin
      test_reset;
      test_li;
      test_arith;
      test_back_to_back;
      test_xor_zero;
      test_nop;
      test_reset_mid;
      test_cnt_wrap;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
- Initiator side of the 8x8 register-file read/write interface in the mini CPU datapath.
- Accepts one instruction per handshake and drives the register file's two combinational read ports to fetch operands.
- Executes a simple ALU operation and issues a single write-back on the register file's write port.
- Multi-cycle, non-pipelined: at most one instruction in flight.

Parameters:
- DATA_WIDTH, 8, operand/result width; must match register file.
- REG_COUNT, 8, number of registers; address width AW = $clog2(REG_COUNT).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADDI, 110 LI, 111 NOP.
- instr_rd  in  AW  destination register.
- instr_rs1  in  AW  source register 1.
- instr_rs2  in  AW  source register 2.
- instr_imm  in  DATA_WIDTH  immediate.
- rf_read_addr1  out  AW  to register file read port 1.
- rf_read_addr2  out  AW  to register file read port 2.
- rf_read_data1  in  DATA_WIDTH  combinational read data, port 1.
- rf_read_data2  in  DATA_WIDTH  combinational read data, port 2.
- rf_write_en  out  1  register-file write strobe.
- rf_write_addr  out  AW  write address.
- rf_write_data  out  DATA_WIDTH  write data.
- result  out  DATA_WIDTH  last computed result, held until next EXEC.
- zero_flag  out  1  result == 0, updated in EXEC.
- carry_flag  out  1  carry-out (ADD/ADDI) or borrow (SUB); 0 for other ops.
- done  out  1  one-cycle pulse in WB cycle.
- retired_cnt  out  CNT_W  count of completed instructions, NOP included.

Behaviour:
- Reset: while rst_n=0, state=IDLE; all captured fields, result, flags, retired_cnt = 0. Outputs: rf_write_en=0, done=0, rf_* addresses/data=0, instr_ready=1 once rst_n deasserts.
- FSM states:
  - IDLE: instr_ready=1. instr_valid&instr_ready at an edge captures op/rd/rs1/rs2/imm and moves to FETCH.
  - FETCH: rf_read_addr1/2 = captured rs1/rs2. At the edge, rf_read_data1/2 are registered into operands A/B. Next state EXEC.
  - EXEC: compute result into result register; update zero_flag/carry_flag. Next state WB.
  - WB: rf_write_en=1 unless op=NOP. rf_write_addr=captured rd, rf_write_data=result, done=1. retired_cnt increments at the edge. Next state IDLE.
- instr_ready=0 in FETCH/EXEC/WB. Input fields are ignored unless accepted.
- Latency: accept at edge E0 -> write lands at edge E3 -> instr_ready=1 again in cycle after E3. Throughput is 1 instruction per 4 cycles.
- Read addresses outside FETCH hold their last value. rf_write_en, done are decoded from state only and must never glitch high outside WB.
- Arithmetic:
  - Operations are modulo 2^DATA_WIDTH.
  - ADD: A+B. SUB: A-B (carry_flag=1 when A<B). ADDI: A+imm. LI: result=imm, B unused.
  - AND/OR/XOR are bitwise.
  - NOP: result register and flags unchanged, no write, done still pulses, counter still increments.
- Hazards: a back-to-back instruction reading the previous rd sees the new value, because the write completes at E3 before the next FETCH. No forwarding is needed.
- rd=rs1=rs2 is legal. Register 0 is an ordinary register.
- retired_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: asynchronous return to IDLE. rf_write_en and done drop immediately; the in-flight instruction is discarded with no write.
- instr_valid held high continuously: the next instruction is accepted in the first IDLE cycle.

Test Plan:
- Reset, then LI r3,0x5A -> rf_write_en=1 with addr 3, data 0x5A exactly 3 cycles after accept; done pulses once; retired_cnt=1.
- With r1=0xF0, r2=0x20: ADD r4,r1,r2 -> write 0x10, carry_flag=1, zero_flag=0. SUB r5,r2,r1 -> write 0x30, carry_flag=1.
- Back-to-back LI r1,0x07 then ADD r2,r1,r1 with instr_valid held high -> second accepted 4 cycles after first; r2 written 0x0E (no stale read); instr_ready low during FETCH/EXEC/WB.
- XOR r6,r1,r1 with r1=0x33 -> write 0x00, zero_flag=1. NOP -> no rf_write_en, done pulses, result/flags unchanged, retired_cnt increments.
- Assert rst_n=0 during EXEC of ADDI r7,r0,0x01 -> rf_write_en never asserts, r7 unchanged, state IDLE, retired_cnt=0, instr_ready=1 after release.
- Preload retired_cnt to 0xFFFF via 65535 NOPs (or a forced value), issue one more -> retired_cnt=0x0000.
